// File: rtl/fpu_pkg.sv
// Shared types and defaults for the floating-point add arbiter slice.
// Used with and without the FADD_ARB_SUB_EN build option.
package fpu_pkg;

    typedef logic [31:0] float32_t;
    typedef logic        req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    localparam int FADD_LATENCY = 2;

    // Round-robin preference: which requester wins when both are valid.
    typedef enum logic {
        RR_PREFER0 = 1'b0,
        RR_PREFER1 = 1'b1
    } rr_state_e;

    function automatic float32_t negateFloat(input float32_t x);
        return {~x[31], x[30:0]};
    endfunction

endpackage

// File: rtl/fadd_arbiter_if.sv
// Bundle of request, fadd-unit and response signals around the fadd arbiter.
// The reqN_sub signals exist only when FADD_ARB_SUB_EN is defined.
interface fadd_arbiter_if #(
    parameter int CNT_W = 3
);
    import fpu_pkg::*;

    logic     req0_valid;
    logic     req1_valid;
    logic     req0_ready;
    logic     req1_ready;
    float32_t req0_x1;
    float32_t req0_x2;
    float32_t req1_x1;
    float32_t req1_x2;
`ifdef FADD_ARB_SUB_EN
    logic     req0_sub;
    logic     req1_sub;
`endif

    float32_t fadd_x1;
    float32_t fadd_x2;
    float32_t fadd_y;
    logic     fadd_ovf;

    logic     rsp0_valid;
    logic     rsp1_valid;
    float32_t rsp_y;
    logic     rsp_ovf;

    logic [CNT_W-1:0] inflight;

    // Arbiter side.
    modport slave (
`ifdef FADD_ARB_SUB_EN
        input  req0_sub, req1_sub,
`endif
        input  req0_valid, req1_valid, req0_x1, req0_x2, req1_x1, req1_x2,
        input  fadd_y, fadd_ovf,
        output req0_ready, req1_ready, fadd_x1, fadd_x2,
        output rsp0_valid, rsp1_valid, rsp_y, rsp_ovf, inflight
    );

    // Requester / fadd-unit environment side.
    modport master (
`ifdef FADD_ARB_SUB_EN
        output req0_sub, req1_sub,
`endif
        output req0_valid, req1_valid, req0_x1, req0_x2, req1_x1, req1_x2,
        output fadd_y, fadd_ovf,
        input  req0_ready, req1_ready, fadd_x1, fadd_x2,
        input  rsp0_valid, rsp1_valid, rsp_y, rsp_ovf, inflight
    );

endinterface

// File: rtl/fadd_rr_arb.sv
// Two-way round-robin grant logic; the preference pointer lives here.
// Grants are combinational and forced low while reset is held.
module fadd_rr_arb
    import fpu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic valid0_i,
    input  logic valid1_i,
    output logic grant0_o,
    output logic grant1_o
);

    rr_state_e rr_q;
    rr_state_e rr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= RR_PREFER0;
        end else begin
            rr_q <= rr_d;
        end
    end

    // After a grant, the other requester gets priority next time.
    always_comb begin
        rr_d = rr_q;
        if (grant0_o) begin
            rr_d = RR_PREFER1;
        end else if (grant1_o) begin
            rr_d = RR_PREFER0;
        end
    end

    always_comb begin
        grant0_o = 1'b0;
        grant1_o = 1'b0;
        if (!rst) begin
            if (valid0_i && valid1_i) begin
                grant0_o = (rr_q == RR_PREFER0);
                grant1_o = (rr_q == RR_PREFER1);
            end else begin
                grant0_o = valid0_i;
                grant1_o = valid1_i;
            end
        end
    end

endmodule

// File: rtl/fadd_arbiter.sv
// Shares one pipelined fadd unit between two requesters, routing results back by tag.
// Define FADD_ARB_SUB_EN to add per-request subtract (sign flip of x2).
module fadd_arbiter
    import fpu_pkg::*;
#(
    parameter int LATENCY = FADD_LATENCY,
    parameter int CNT_W   = 3
)
(
    input  logic           clk,
    input  logic           rst,
    fadd_arbiter_if.slave  bus
);

    logic     grant0;
    logic     grant1;
    logic     xfer;
    req_id_t  grantId;
    float32_t selX1;
    float32_t selX2;

    float32_t fadd_x1_q;
    float32_t fadd_x1_d;
    float32_t fadd_x2_q;
    float32_t fadd_x2_d;

    tag_t     tag_q [LATENCY+1];
    tag_t     tag_d [LATENCY+1];
    tag_t     respTag;

    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] inflight_d;

    fadd_rr_arb u_rr_arb (
        .clk      (clk),
        .rst      (rst),
        .valid0_i (bus.req0_valid),
        .valid1_i (bus.req1_valid),
        .grant0_o (grant0),
        .grant1_o (grant1)
    );

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign xfer           = grant0 | grant1;
    assign grantId        = req_id_t'(grant1);

    always_comb begin
        selX1 = grant1 ? bus.req1_x1 : bus.req0_x1;
        selX2 = grant1 ? bus.req1_x2 : bus.req0_x2;
`ifdef FADD_ARB_SUB_EN
        if ((grant0 && bus.req0_sub) || (grant1 && bus.req1_sub)) begin
            selX2 = negateFloat(selX2);
        end
`endif
    end

    // Operands hold between transfers so the fadd unit sees stable inputs.
    always_comb begin
        fadd_x1_d = fadd_x1_q;
        fadd_x2_d = fadd_x2_q;
        if (xfer) begin
            fadd_x1_d = selX1;
            fadd_x2_d = selX2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fadd_x1_q <= '0;
            fadd_x2_q <= '0;
        end else begin
            fadd_x1_q <= fadd_x1_d;
            fadd_x2_q <= fadd_x2_d;
        end
    end

    // Stage 0 lines up with the registered operands; the last stage with fadd_y.
    always_comb begin
        tag_d[0] = '{valid: xfer, id: grantId};
        for (int i = 1; i <= LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i <= LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign respTag = tag_q[LATENCY];

    always_comb begin
        inflight_d = inflight_q;
        if (xfer && !respTag.valid) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!xfer && respTag.valid) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign bus.fadd_x1    = fadd_x1_q;
    assign bus.fadd_x2    = fadd_x2_q;
    assign bus.rsp0_valid = respTag.valid && (respTag.id == 1'b0);
    assign bus.rsp1_valid = respTag.valid && (respTag.id == 1'b1);
    assign bus.rsp_y      = bus.fadd_y;
    assign bus.rsp_ovf    = bus.fadd_ovf;
    assign bus.inflight   = inflight_q;

endmodule

// File: tb/tb_fadd_arbiter.sv
// Self-checking bench for fadd_arbiter with a latency-matched fadd unit model.
// Build with FADD_ARB_SUB_EN defined to also exercise the subtract path.
module tb_fadd_arbiter;
    import fpu_pkg::*;

    localparam int LAT = 2;
    localparam int CW  = 3;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   testsRun = 0;
    int   testsFailed = 0;
    int   rspSeen = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    fadd_arbiter_if #(.CNT_W(CW)) bus ();

    fadd_arbiter #(.LATENCY(LAT), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in fadd unit: exact sums for the vectors used, a fixed mix otherwise.
    function automatic logic [32:0] faddRef(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_3F800000: return {1'b0, 32'h40000000};
            64'h40000000_3F800000: return {1'b0, 32'h40400000};
            64'h7F7FFFFF_7F7FFFFF: return {1'b1, 32'h7F800000};
            64'h40400000_BF800000: return {1'b0, 32'h40000000};
            default:               return {a[0], a ^ {b[15:0], b[31:16]}};
        endcase
    endfunction

    logic [32:0] faddPipe [LAT];

    always @(posedge clk) begin
        faddPipe[0] <= faddRef(bus.fadd_x1, bus.fadd_x2);
        for (int i = 1; i < LAT; i++) faddPipe[i] <= faddPipe[i-1];
    end

    assign bus.fadd_y   = faddPipe[LAT-1][31:0];
    assign bus.fadd_ovf = faddPipe[LAT-1][32];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Transaction-level model: grants from the round-robin rule, responses as a
    // queue of results due LAT+1 cycles after their transfer.
    typedef struct {
        int          due;
        bit          id;
        logic [31:0] y;
        bit          ovf;
    } rsp_t;

    rsp_t        expQ[$];
    rsp_t        head;
    int          rrModel = 0;
    logic [31:0] expX1 = '0;
    logic [31:0] expX2 = '0;
    bit          g0, g1, s, exp0, exp1;
    logic [31:0] opA, opB;
    logic [32:0] res;
    int          inflightExp;

    always @(negedge clk) begin
        if (bus.rsp0_valid || bus.rsp1_valid) rspSeen++;
        if (rst) begin
            checkOutput("ready0_in_reset", 64'(bus.req0_ready), 64'd0);
            checkOutput("ready1_in_reset", 64'(bus.req1_ready), 64'd0);
            expQ.delete();
            rrModel = 0;
            expX1 = '0;
            expX2 = '0;
        end else begin
            g0 = bus.req0_valid && (!bus.req1_valid || rrModel == 0);
            g1 = bus.req1_valid && !g0;
            checkOutput("ready0", 64'(bus.req0_ready), 64'(g0));
            checkOutput("ready1", 64'(bus.req1_ready), 64'(g1));
            checkOutput("fadd_x1", 64'(bus.fadd_x1), 64'(expX1));
            checkOutput("fadd_x2", 64'(bus.fadd_x2), 64'(expX2));
            inflightExp = expQ.size();
            checkOutput("inflight", 64'(bus.inflight), 64'(inflightExp));
            exp0 = 1'b0;
            exp1 = 1'b0;
            if (expQ.size() > 0 && expQ[0].due == cyc) begin
                head = expQ.pop_front();
                exp0 = !head.id;
                exp1 = head.id;
            end
            checkOutput("rsp0_valid", 64'(bus.rsp0_valid), 64'(exp0));
            checkOutput("rsp1_valid", 64'(bus.rsp1_valid), 64'(exp1));
            if (exp0 || exp1) begin
                checkOutput("rsp_y", 64'(bus.rsp_y), 64'(head.y));
                checkOutput("rsp_ovf", 64'(bus.rsp_ovf), 64'(head.ovf));
            end
            if (g0 || g1) begin
                opA = g0 ? bus.req0_x1 : bus.req1_x1;
                opB = g0 ? bus.req0_x2 : bus.req1_x2;
                s = 1'b0;
`ifdef FADD_ARB_SUB_EN
                s = g0 ? bus.req0_sub : bus.req1_sub;
`endif
                if (s) opB[31] = ~opB[31];
                res = faddRef(opA, opB);
                expQ.push_back('{due: cyc + LAT + 1, id: g1, y: res[31:0], ovf: res[32]});
                expX1 = opA;
                expX2 = opB;
                rrModel = g0 ? 1 : 0;
            end
        end
    end

    task automatic applyStimulus(input bit v0, input logic [31:0] a0, input logic [31:0] b0, input bit s0,
                                 input bit v1, input logic [31:0] a1, input logic [31:0] b1, input bit s1);
        bus.req0_valid = v0;
        bus.req0_x1    = a0;
        bus.req0_x2    = b0;
        bus.req1_valid = v1;
        bus.req1_x1    = a1;
        bus.req1_x2    = b1;
`ifdef FADD_ARB_SUB_EN
        bus.req0_sub   = s0;
        bus.req1_sub   = s1;
`else
        if (s0 || s1) $display("[TB] note: subtract requested in a build without it");
`endif
    endtask

    task automatic applyIdle();
        applyStimulus(0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic midCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic resetPulse();
        nextCycle();
        rst = 1'b1;
        applyIdle();
        nextCycle();
        rst = 1'b0;
    endtask

    int          seenBefore;
    logic [15:0] pat0;
    logic [15:0] pat1;
    int          infTab [8];

    initial begin
        rst = 1'b1;
        applyIdle();
        nextCycle();
        nextCycle();
        rst = 1'b0;
        midCycle();
        checkOutput("reset_inflight", 64'(bus.inflight), 64'd0);
        checkOutput("reset_fadd_x1", 64'(bus.fadd_x1), 64'd0);
        checkOutput("reset_fadd_x2", 64'(bus.fadd_x2), 64'd0);
        checkOutput("reset_rsp0", 64'(bus.rsp0_valid), 64'd0);
        checkOutput("reset_rsp1", 64'(bus.rsp1_valid), 64'd0);

        // Single request 1.0 + 1.0 on requester 0.
        nextCycle();
        applyStimulus(1, 32'h3F800000, 32'h3F800000, 0, 0, '0, '0, 0);
        midCycle();
        checkOutput("t1_ready0", 64'(bus.req0_ready), 64'd1);
        nextCycle();
        applyIdle();
        midCycle();
        checkOutput("t1_inflight_a", 64'(bus.inflight), 64'd1);
        checkOutput("t1_fadd_x1", 64'(bus.fadd_x1), 64'h3F800000);
        nextCycle();
        midCycle();
        checkOutput("t1_inflight_b", 64'(bus.inflight), 64'd1);
        nextCycle();
        midCycle();
        checkOutput("t1_rsp0", 64'(bus.rsp0_valid), 64'd1);
        checkOutput("t1_rsp1", 64'(bus.rsp1_valid), 64'd0);
        checkOutput("t1_rsp_y", 64'(bus.rsp_y), 64'h40000000);
        checkOutput("t1_rsp_ovf", 64'(bus.rsp_ovf), 64'd0);
        nextCycle();
        midCycle();
        checkOutput("t1_inflight_c", 64'(bus.inflight), 64'd0);

        // Both requesters valid four cycles in a row.
        resetPulse();
        infTab = '{0, 1, 2, 3, 3, 2, 1, 0};
        for (int i = 0; i < 8; i++) begin
            nextCycle();
            if (i < 4) applyStimulus(1, 32'h40000000, 32'h3F800000, 0, 1, 32'h3F800000, 32'h3F800000, 0);
            else       applyIdle();
            midCycle();
            if (i < 4) checkOutput("t2_ready0", 64'(bus.req0_ready), 64'((i % 2) == 0));
            if (i >= 3 && i <= 6) begin
                checkOutput("t2_rsp0", 64'(bus.rsp0_valid), 64'(((i - 3) % 2) == 0));
                checkOutput("t2_rsp1", 64'(bus.rsp1_valid), 64'(((i - 3) % 2) == 1));
                checkOutput("t2_rsp_y", 64'(bus.rsp_y), ((i - 3) % 2 == 0) ? 64'h40400000 : 64'h40000000);
            end
            checkOutput("t2_inflight", 64'(bus.inflight), 64'(infTab[i]));
        end

        // Overflow on requester 1.
        nextCycle();
        applyStimulus(0, '0, '0, 0, 1, 32'h7F7FFFFF, 32'h7F7FFFFF, 0);
        midCycle();
        checkOutput("t3_ready1", 64'(bus.req1_ready), 64'd1);
        for (int k = 1; k <= 3; k++) begin
            nextCycle();
            applyIdle();
            midCycle();
        end
        checkOutput("t3_rsp1", 64'(bus.rsp1_valid), 64'd1);
        checkOutput("t3_rsp0", 64'(bus.rsp0_valid), 64'd0);
        checkOutput("t3_rsp_ovf", 64'(bus.rsp_ovf), 64'd1);

`ifdef FADD_ARB_SUB_EN
        // 3.0 - 1.0 through the subtract path.
        nextCycle();
        applyStimulus(1, 32'h40400000, 32'h3F800000, 1, 0, '0, '0, 0);
        midCycle();
        nextCycle();
        applyIdle();
        midCycle();
        checkOutput("t4_fadd_x2", 64'(bus.fadd_x2), 64'hBF800000);
        nextCycle();
        midCycle();
        nextCycle();
        midCycle();
        checkOutput("t4_rsp0", 64'(bus.rsp0_valid), 64'd1);
        checkOutput("t4_rsp_y", 64'(bus.rsp_y), 64'h40000000);
`endif

        // Reset one cycle after the second of two transfers.
        nextCycle();
        applyStimulus(1, 32'h3F800000, 32'h3F800000, 0, 0, '0, '0, 0);
        nextCycle();
        applyStimulus(0, '0, '0, 0, 1, 32'h40000000, 32'h3F800000, 0);
        nextCycle();
        applyIdle();
        rst = 1'b1;
        midCycle();
        seenBefore = rspSeen;
        nextCycle();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            midCycle();
            nextCycle();
        end
        checkOutput("t5_no_rsp", 64'(rspSeen - seenBefore), 64'd0);
        checkOutput("t5_inflight", 64'(bus.inflight), 64'd0);
        applyStimulus(1, 32'h3F800000, 32'h3F800000, 0, 1, 32'h40000000, 32'h3F800000, 0);
        midCycle();
        checkOutput("t5_rr_ready0", 64'(bus.req0_ready), 64'd1);
        checkOutput("t5_rr_ready1", 64'(bus.req1_ready), 64'd0);

        // Directed mix of request patterns, checked cycle by cycle by the model.
        pat0 = 16'b1011_0110_1110_0101;
        pat1 = 16'b1101_1011_0011_1100;
        for (int i = 0; i < 16; i++) begin
            nextCycle();
            applyStimulus(pat0[i], 32'h3F800000 + 32'(i), 32'h40000000 ^ 32'(i * 7), i[0],
                          pat1[i], 32'h41000000 + 32'(i * 3), 32'h3F000000 + 32'(i), !i[0]);
        end
        for (int k = 0; k < 6; k++) begin
            nextCycle();
            applyIdle();
        end
        midCycle();
        checkOutput("t6_drained", 64'(bus.inflight), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
